// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc} with flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass path.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic [31:0]   in_instr,
   input  logic [31:0]   in_pc,
   output logic          in_ready,
   output logic          out_valid,
   output logic [31:0]   out_instr,
   output logic [31:0]   out_pc,
   input  logic          out_ready,
   input  logic          flush,
   output logic [AW:0]   count
);

   localparam logic [AW:0] Full = (AW+1)'(DEPTH);

   logic [31:0]   mem_instr_q [DEPTH];
   logic [31:0]   mem_pc_q    [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push, pop;
   logic          empty;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q != Full);
   assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;
   // An empty queue forwards fetch straight to decode unless flushing.
   assign bypass    = empty && in_valid && !flush;
   assign out_valid = !empty || bypass;
   assign out_instr = empty ? in_instr : mem_instr_q[rd_ptr_q];
   assign out_pc    = empty ? in_pc    : mem_pc_q[rd_ptr_q];
   // A bypassed word consumed in the same cycle is never stored.
   assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
   assign out_valid = !empty;
   assign out_instr = mem_instr_q[rd_ptr_q];
   assign out_pc    = mem_pc_q[rd_ptr_q];
   assign push      = in_valid && in_ready;
`endif

   assign pop = !empty && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_instr_q[wr_ptr_q] <= in_instr;
         mem_pc_q[wr_ptr_q]    <= in_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: fill/drain, full, stream, flush, reset, bypass.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        flush;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   logic [31:0] fill_instr [4];

   fetch_queue #(
      .DEPTH (4),
      .AW    (2)
   ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      fill_instr[0] = 32'h0000_0013;
      fill_instr[1] = 32'h0010_0093;
      fill_instr[2] = 32'h0020_0113;
      fill_instr[3] = 32'h0030_0193;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);

      // Fill to DEPTH.
      for (int i = 0; i < 4; i++) push_word(fill_instr[i], 32'(4 * i));
      #1;
      check("fill_count", 32'(count), 32'd4);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      check("fill_out_valid", 32'(out_valid), 32'd1);
      check("fill_head_pc", out_pc, 32'h0);

      // Push while full must be dropped.
      push_word(32'hDEAD_BEEF, 32'h99);
      #1;
      check("full_count", 32'(count), 32'd4);
      check("full_head_instr", out_instr, fill_instr[0]);

      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain_pc%0d", i), out_pc, 32'(4 * i));
         check($sformatf("drain_instr%0d", i), out_instr, fill_instr[i]);
         step();
      end
      out_ready = 1'b0;
      #1;
      check("drain_count", 32'(count), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Streaming at count 2 across pointer wrap.
      push_word(32'hA000_0000, 32'h1000);
      push_word(32'hA000_0001, 32'h1004);
      for (int k = 0; k < 10; k++) begin
         in_valid  = 1'b1;
         in_instr  = 32'hA000_0002 + 32'(k);
         in_pc     = 32'h1008 + 32'(4 * k);
         out_ready = 1'b1;
         #1;
         check($sformatf("stream_pc%0d", k), out_pc, 32'h1000 + 32'(4 * k));
         step();
         check($sformatf("stream_count%0d", k), 32'(count), 32'd2);
      end
      in_valid = 1'b0;
      #1;
      check("stream_tail_pc0", out_pc, 32'h1028);
      step();
      check("stream_tail_pc1", out_pc, 32'h102C);
      step();
      out_ready = 1'b0;
      check("stream_end_count", 32'(count), 32'd0);

      // Flush at count 3 with concurrent push and pop.
      push_word(32'hB000_0000, 32'h20);
      push_word(32'hB000_0001, 32'h24);
      push_word(32'hB000_0002, 32'h28);
      in_valid  = 1'b1;
      in_instr  = 32'hB000_0040;
      in_pc     = 32'h40;
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1;
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      push_word(32'hB000_0100, 32'h100);
      #1;
      check("flush_next_pc", out_pc, 32'h100);
      check("flush_next_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset mid-stream at count 2.
      push_word(32'hC000_0000, 32'h50);
      push_word(32'hC000_0001, 32'h54);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      #1;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      push_word(32'hC000_0200, 32'h200);
      #1;
      check("midrst_next_pc", out_pc, 32'h200);
      check("midrst_next_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      check("pre_bypass_count", 32'(count), 32'd0);

      // Empty queue, word offered with decode ready.
      in_valid  = 1'b1;
      in_instr  = 32'h1234_5678;
      in_pc     = 32'h300;
      out_ready = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("bypass_out_valid", 32'(out_valid), 32'd1);
      check("bypass_out_pc", out_pc, 32'h300);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("bypass_count", 32'(count), 32'd0);
      check("bypass_after_valid", 32'(out_valid), 32'd0);
`else
      check("nobypass_out_valid", 32'(out_valid), 32'd0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("nobypass_next_valid", 32'(out_valid), 32'd1);
      check("nobypass_next_pc", out_pc, 32'h300);
      check("nobypass_count", 32'(count), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
